// File: rtl/lcd_pixel_unpack_ctrl.sv
// lcd_pixel_unpack_ctrl
// Sequences the TFT/STN data encoder: pulls 32-bit frame-buffer words from
// the DMA FIFO, unpacks each word into right-aligned pixels according to the
// bpp mode latched at frame start, and tracks pixel/line position so that
// line and frame boundaries are flagged alongside the matching pixel.
//
// Ports:
//   hclk, hresetn       clock, asynchronous active-low reset
//   lcden               controller enable (low forces IDLE, flushes buffer)
//   lcdbpp              pixel mode, sampled only in IDLE and FRAME
//   ppl, lpp            pixels per line - 1, lines per frame - 1
//   fifo_data/valid     frame-buffer word stream from the DMA FIFO
//   fifo_ready          word accepted when fifo_valid & fifo_ready
//   pstoencode_data_in  current pixel, right-aligned, zero-extended
//   pix_valid/ready     pixel handshake towards the encoder
//   line_end/frame_end  high together with the last pixel of a line/frame
//   underflow           sticky starvation flag, cleared by underflow_clr
module lcd_pixel_unpack_ctrl #(
  parameter int PPL_W = 10,
  parameter int LPP_W = 10
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             lcden,
  input  logic [2:0]       lcdbpp,
  input  logic [PPL_W-1:0] ppl,
  input  logic [LPP_W-1:0] lpp,
  input  logic [31:0]      fifo_data,
  input  logic             fifo_valid,
  output logic             fifo_ready,
  output logic [23:0]      pstoencode_data_in,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             line_end,
  output logic             frame_end,
  output logic             underflow,
  input  logic             underflow_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FRAME = 2'd2
  } state_t;

  state_t           state_r;
  logic [2:0]       bpp_r;
  logic [31:0]      word_r;
  logic             full_r;
  logic [4:0]       pidx_r;
  logic [PPL_W-1:0] pix_cnt_r;
  logic [LPP_W-1:0] line_cnt_r;
  logic             first_r;      // first cycle after entering RUN
  logic             underflow_r;

  logic             last_in_word_s;
  logic             line_end_s;
  logic             frame_end_s;
  logic             pix_hs_s;
  logic             word_done_s;
  logic             fifo_ready_s;
  logic             load_s;
  logic [23:0]      pix_data_s;

  // Index of the last pixel held in one word for a given mode.
  function automatic logic [4:0] last_pidx(input logic [2:0] bpp);
    logic [4:0] r;
    case (bpp)
      3'b000:  r = 5'd31;
      3'b001:  r = 5'd15;
      3'b010:  r = 5'd7;
      3'b011:  r = 5'd3;
      3'b100:  r = 5'd1;
      3'b101:  r = 5'd0;
      3'b110:  r = 5'd1;
      3'b111:  r = 5'd1;
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // Extract pixel pidx of a word; 12bpp pixels sit in the low 12 bits of
  // each halfword and 24bpp ignores the top byte.
  function automatic logic [23:0] field_sel(input logic [31:0] word,
                                            input logic [2:0]  bpp,
                                            input logic [4:0]  pidx);
    logic [31:0] sh;
    logic [23:0] f;
    sh = 32'd0;
    f  = 24'd0;
    case (bpp)
      3'b000: begin sh = word >> pidx;                  f = {23'd0, sh[0]};     end
      3'b001: begin sh = word >> {pidx[3:0], 1'b0};     f = {22'd0, sh[1:0]};   end
      3'b010: begin sh = word >> {pidx[2:0], 2'b00};    f = {20'd0, sh[3:0]};   end
      3'b011: begin sh = word >> {pidx[1:0], 3'b000};   f = {16'd0, sh[7:0]};   end
      3'b100: begin sh = word >> {pidx[0], 4'b0000};    f = {8'd0, sh[15:0]};   end
      3'b101: begin sh = word;                          f = sh[23:0];           end
      3'b110: begin sh = word >> {pidx[0], 4'b0000};    f = {8'd0, sh[15:0]};   end
      3'b111: begin sh = word >> {pidx[0], 4'b0000};    f = {12'd0, sh[11:0]};  end
      default: begin sh = 32'd0;                        f = 24'd0;              end
    endcase
    return f;
  endfunction

  // Handshake and boundary decode from the registered buffer and counters.
  always_comb begin
    last_in_word_s = (pidx_r == last_pidx(bpp_r));
    line_end_s     = full_r & (pix_cnt_r == ppl);
    frame_end_s    = line_end_s & (line_cnt_r == lpp);
    pix_hs_s       = full_r & pix_ready;
    // a line end also retires the word: lines always start on a word boundary
    word_done_s    = pix_hs_s & (last_in_word_s | line_end_s);
    // no word is taken when the buffer is about to be flushed (frame end or
    // enable dropping), otherwise it would be lost
    if ((state_r == ST_RUN) && lcden && !(pix_hs_s && frame_end_s)) begin
      fifo_ready_s = ~full_r | word_done_s;
    end else begin
      fifo_ready_s = 1'b0;
    end
    load_s = fifo_ready_s & fifo_valid;
  end

  // Pixel output is taken from the registered word only.
  always_comb begin
    pix_data_s = 24'd0;
    if (full_r) begin
      pix_data_s = field_sel(word_r, bpp_r, pidx_r);
    end else begin
      pix_data_s = 24'd0;
    end
  end

  // Control FSM with word buffer, pixel index and position counters.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r    <= ST_IDLE;
      bpp_r      <= 3'b000;
      word_r     <= 32'd0;
      full_r     <= 1'b0;
      pidx_r     <= 5'd0;
      pix_cnt_r  <= '0;
      line_cnt_r <= '0;
      first_r    <= 1'b0;
    end else if (!lcden) begin
      state_r    <= ST_IDLE;
      full_r     <= 1'b0;
      pidx_r     <= 5'd0;
      pix_cnt_r  <= '0;
      line_cnt_r <= '0;
      first_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bpp_r      <= lcdbpp;
          full_r     <= 1'b0;
          pidx_r     <= 5'd0;
          pix_cnt_r  <= '0;
          line_cnt_r <= '0;
          first_r    <= 1'b1;
          state_r    <= ST_RUN;
        end
        ST_RUN: begin
          first_r <= 1'b0;
          if (pix_hs_s) begin
            if (line_end_s) begin
              pix_cnt_r <= '0;
              if (frame_end_s) begin
                line_cnt_r <= '0;
                state_r    <= ST_FRAME;
              end else begin
                line_cnt_r <= line_cnt_r + LPP_W'(1);
              end
            end else begin
              pix_cnt_r <= pix_cnt_r + PPL_W'(1);
            end
          end
          if (load_s) begin
            word_r <= fifo_data;
            full_r <= 1'b1;
            pidx_r <= 5'd0;
          end else if (word_done_s) begin
            full_r <= 1'b0;
            pidx_r <= 5'd0;
          end else if (pix_hs_s) begin
            pidx_r <= pidx_r + 5'd1;
          end
        end
        ST_FRAME: begin
          bpp_r   <= lcdbpp;
          full_r  <= 1'b0;
          pidx_r  <= 5'd0;
          first_r <= 1'b1;
          state_r <= ST_RUN;
        end
        default: begin
          state_r <= ST_IDLE;
          full_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky underflow flag; a new starvation event wins over a clear.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      underflow_r <= 1'b0;
    end else if ((state_r == ST_RUN) && !first_r && pix_ready && !full_r && !fifo_valid) begin
      underflow_r <= 1'b1;
    end else if (underflow_clr) begin
      underflow_r <= 1'b0;
    end
  end

  assign fifo_ready         = fifo_ready_s;
  assign pix_valid          = full_r;
  assign pstoencode_data_in = pix_data_s;
  assign line_end           = line_end_s;
  assign frame_end          = frame_end_s;
  assign underflow          = underflow_r;

endmodule

// File: tb/tb_lcd_pixel_unpack_ctrl.sv
// Directed bench for lcd_pixel_unpack_ctrl. Inputs change just after the
// falling edge and outputs are sampled 1 time unit later, well before the
// next rising edge.
module tb_lcd_pixel_unpack_ctrl;

  logic        hclk;
  logic        hresetn;
  logic        lcden;
  logic [2:0]  lcdbpp;
  logic [9:0]  ppl;
  logic [9:0]  lpp;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ready;
  logic [23:0] pstoencode_data_in;
  logic        pix_valid;
  logic        pix_ready;
  logic        line_end;
  logic        frame_end;
  logic        underflow;
  logic        underflow_clr;

  int checks = 0;
  int errors = 0;

  lcd_pixel_unpack_ctrl #(.PPL_W(10), .LPP_W(10)) dut (
    .hclk               (hclk),
    .hresetn            (hresetn),
    .lcden              (lcden),
    .lcdbpp             (lcdbpp),
    .ppl                (ppl),
    .lpp                (lpp),
    .fifo_data          (fifo_data),
    .fifo_valid         (fifo_valid),
    .fifo_ready         (fifo_ready),
    .pstoencode_data_in (pstoencode_data_in),
    .pix_valid          (pix_valid),
    .pix_ready          (pix_ready),
    .line_end           (line_end),
    .frame_end          (frame_end),
    .underflow          (underflow),
    .underflow_clr      (underflow_clr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fifo_ready"}, {31'd0, fifo_ready}, 32'd0);
    check({tag, "_pix_valid"},  {31'd0, pix_valid},  32'd0);
    check({tag, "_data"},       {8'd0, pstoencode_data_in}, 32'd0);
    check({tag, "_line_end"},   {31'd0, line_end},   32'd0);
    check({tag, "_frame_end"},  {31'd0, frame_end},  32'd0);
    check({tag, "_underflow"},  {31'd0, underflow},  32'd0);
  endtask

  initial begin
    logic [31:0] bp_words [4];
    int e;
    int w;

    // ---------------- reset values
    hresetn = 1'b0; lcden = 1'b0; lcdbpp = 3'b000; ppl = 10'd100; lpp = 10'd10;
    fifo_data = 32'd0; fifo_valid = 1'b0; pix_ready = 1'b0; underflow_clr = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge hclk); hresetn = 1'b1;
    @(negedge hclk);

    // ---------------- 24bpp, two words back to back
    @(negedge hclk);
    lcden = 1'b1; lcdbpp = 3'b101; fifo_valid = 1'b1; fifo_data = 32'hAA112233; pix_ready = 1'b1;
    #1; check("b24_idle_ready", {31'd0, fifo_ready}, 32'd0);
    @(negedge hclk); #1;
    check("b24_empty_ready", {31'd0, fifo_ready}, 32'd1);
    check("b24_empty_valid", {31'd0, pix_valid}, 32'd0);
    @(negedge hclk); fifo_data = 32'h00445566; #1;
    check("b24_pix0", {8'd0, pstoencode_data_in}, 32'h00112233);
    check("b24_pix0_ready", {31'd0, fifo_ready}, 32'd1);
    @(negedge hclk); fifo_valid = 1'b0; pix_ready = 1'b0; #1;
    check("b24_pix1", {8'd0, pstoencode_data_in}, 32'h00445566);
    check("b24_pix1_valid", {31'd0, pix_valid}, 32'd1);

    // ---------------- lcden drop mid-line
    @(negedge hclk); lcden = 1'b0; #1;
    @(negedge hclk); #1;
    check("drop_ready", {31'd0, fifo_ready}, 32'd0);
    check("drop_valid", {31'd0, pix_valid}, 32'd0);
    check("drop_data", {8'd0, pstoencode_data_in}, 32'd0);

    // ---------------- 4bpp with line end at pixel 9
    @(negedge hclk);
    lcden = 1'b1; lcdbpp = 3'b010; ppl = 10'd9; lpp = 10'd10;
    fifo_valid = 1'b1; fifo_data = 32'h76543210; pix_ready = 1'b1;
    @(negedge hclk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge hclk);
      fifo_data = (i < 8) ? 32'hFEDCBA98 : 32'h87654321;
      #1;
      check($sformatf("b4_pix%0d", i), {8'd0, pstoencode_data_in}, i);
      check($sformatf("b4_le%0d", i), {31'd0, line_end}, (i == 9) ? 32'd1 : 32'd0);
      check($sformatf("b4_rdy%0d", i), {31'd0, fifo_ready}, (i == 7 || i == 9) ? 32'd1 : 32'd0);
    end
    @(negedge hclk); #1;
    check("b4_next_line_pix0", {8'd0, pstoencode_data_in}, 32'h1);
    check("b4_next_line_le", {31'd0, line_end}, 32'd0);

    // ---------------- 16bpp 5:6:5
    @(negedge hclk); lcden = 1'b0; fifo_valid = 1'b0; pix_ready = 1'b0;
    @(negedge hclk);
    lcden = 1'b1; lcdbpp = 3'b110; ppl = 10'd100; fifo_valid = 1'b1; fifo_data = 32'h1234ABCD;
    @(negedge hclk);
    @(negedge hclk); pix_ready = 1'b1; #1;
    check("b16_pix0", {8'd0, pstoencode_data_in}, 32'h0000ABCD);
    check("b16_pix0_ready", {31'd0, fifo_ready}, 32'd0);
    @(negedge hclk); #1;
    check("b16_pix1", {8'd0, pstoencode_data_in}, 32'h00001234);
    check("b16_pix1_ready", {31'd0, fifo_ready}, 32'd1);

    // ---------------- backpressure, 8bpp, random pix_ready
    bp_words[0] = 32'h44332211; bp_words[1] = 32'h88776655;
    bp_words[2] = 32'hCCBBAA99; bp_words[3] = 32'h00FFEEDD;
    @(negedge hclk); lcden = 1'b0; fifo_valid = 1'b0; pix_ready = 1'b0;
    @(negedge hclk);
    lcden = 1'b1; lcdbpp = 3'b011; ppl = 10'd1023; fifo_valid = 1'b1; fifo_data = bp_words[0];
    @(negedge hclk); #1;
    check("bp_first_ready", {31'd0, fifo_ready}, 32'd1);
    e = 0; w = 1;
    for (int k = 0; k < 80 && e < 12; k++) begin
      @(negedge hclk);
      pix_ready = 1'($urandom_range(0, 1));
      fifo_data = bp_words[w];
      #1;
      check($sformatf("bp_valid_k%0d", k), {31'd0, pix_valid}, 32'd1);
      check($sformatf("bp_data_k%0d", k), {8'd0, pstoencode_data_in}, 32'(17 * (e + 1)));
      if (pix_ready) e++;
      if (fifo_ready && w < 3) w++;
    end
    check("bp_all_pixels_seen", e, 32'd12);

    // ---------------- frame end: ppl=3, lpp=1, 8bpp
    @(negedge hclk); lcden = 1'b0; fifo_valid = 1'b0; pix_ready = 1'b0;
    @(negedge hclk);
    lcden = 1'b1; lcdbpp = 3'b011; ppl = 10'd3; lpp = 10'd1;
    fifo_valid = 1'b1; fifo_data = 32'h03020100; pix_ready = 1'b1;
    @(negedge hclk);
    for (int i = 0; i < 8; i++) begin
      @(negedge hclk);
      fifo_data = (i < 4) ? 32'h13121110 : 32'h23222120;
      #1;
      check($sformatf("fr_pix%0d", i), {8'd0, pstoencode_data_in}, 32'((i / 4) * 16 + (i % 4)));
      check($sformatf("fr_le%0d", i), {31'd0, line_end}, ((i % 4) == 3) ? 32'd1 : 32'd0);
      check($sformatf("fr_fe%0d", i), {31'd0, frame_end}, (i == 7) ? 32'd1 : 32'd0);
    end
    @(negedge hclk); #1;
    check("fr_frame_valid", {31'd0, pix_valid}, 32'd0);
    check("fr_frame_ready", {31'd0, fifo_ready}, 32'd0);
    check("fr_frame_fe", {31'd0, frame_end}, 32'd0);
    @(negedge hclk); #1;
    check("fr_restart_ready", {31'd0, fifo_ready}, 32'd1);
    check("fr_restart_valid", {31'd0, pix_valid}, 32'd0);
    @(negedge hclk); #1;
    check("fr_restart_pix0", {8'd0, pstoencode_data_in}, 32'h20);
    check("fr_restart_le", {31'd0, line_end}, 32'd0);

    // ---------------- underflow
    @(negedge hclk); lcden = 1'b0; fifo_valid = 1'b0; pix_ready = 1'b0; #1;
    check("uf_none_before", {31'd0, underflow}, 32'd0);
    @(negedge hclk); lcden = 1'b1; pix_ready = 1'b1;
    @(negedge hclk); #1;
    check("uf_first_run_cycle", {31'd0, underflow}, 32'd0);
    @(negedge hclk); #1;
    check("uf_not_yet", {31'd0, underflow}, 32'd0);
    @(negedge hclk); pix_ready = 1'b0; #1;
    check("uf_set", {31'd0, underflow}, 32'd1);
    @(negedge hclk); underflow_clr = 1'b1; #1;
    check("uf_sticky", {31'd0, underflow}, 32'd1);
    @(negedge hclk); pix_ready = 1'b1; #1;
    check("uf_cleared", {31'd0, underflow}, 32'd0);
    @(negedge hclk); underflow_clr = 1'b0; pix_ready = 1'b0; #1;
    check("uf_set_beats_clr", {31'd0, underflow}, 32'd1);

    // ---------------- asynchronous reset at pixel 5
    @(negedge hclk); lcden = 1'b0;
    @(negedge hclk);
    lcden = 1'b1; lcdbpp = 3'b011; ppl = 10'd7; lpp = 10'd3;
    fifo_valid = 1'b1; fifo_data = 32'h03020100; pix_ready = 1'b1;
    @(negedge hclk);
    for (int i = 0; i < 6; i++) begin
      @(negedge hclk); fifo_data = 32'h07060504; #1;
      check($sformatf("rst_pre_pix%0d", i), {8'd0, pstoencode_data_in}, i);
    end
    #2 hresetn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge hclk); hresetn = 1'b1; fifo_data = 32'h0B0A0908;
    @(negedge hclk);
    for (int j = 0; j < 8; j++) begin
      @(negedge hclk); fifo_data = 32'h0F0E0D0C; #1;
      check($sformatf("rst_post_pix%0d", j), {8'd0, pstoencode_data_in}, 32'(8 + j));
      check($sformatf("rst_post_le%0d", j), {31'd0, line_end}, (j == 7) ? 32'd1 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
